// File: rtl/fusion_unit_pipe_if.sv
// Operand, partial-sum and systolic-forward bundle of one fusion PE.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; master is the PE's neighbour, slave is the PE.
interface fusion_unit_pipe_if #(
    parameter int DATA_W = 32,
    parameter int PSUM_W = 32
);
    logic [1:0]               cfg_in_bw;
    logic [1:0]               cfg_wt_bw;
    logic                     cfg_in_signed;
    logic                     cfg_wt_signed;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [DATA_W-1:0]        input_forward;
    logic [DATA_W-1:0]        weight;
    logic signed [PSUM_W-1:0] psum_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [PSUM_W-1:0] psum;
    logic                     sat;
    logic [DATA_W-1:0]        input_to_right;
    logic                     fwd_valid;

    modport master (
        output cfg_in_bw, cfg_wt_bw, cfg_in_signed, cfg_wt_signed,
        output in_valid, in_last, input_forward, weight, psum_in, out_ready,
        input  in_ready, out_valid, psum, sat, input_to_right, fwd_valid
    );

    modport slave (
        input  cfg_in_bw, cfg_wt_bw, cfg_in_signed, cfg_wt_signed,
        input  in_valid, in_last, input_forward, weight, psum_in, out_ready,
        output in_ready, out_valid, psum, sat, input_to_right, fwd_valid
    );
endinterface

// File: rtl/fusion_unit_pipe.sv
// Precision-configurable (2/4/8b) dot product with group accumulation, psum add and optional clamp.
// Latency: last beat accepted at cycle t -> out_valid at t+2; forward copy at t+1.
// Backpressure: S1 refills only when S2 advances; only last beats stall on out_valid && !out_ready.
module fusion_unit_pipe #(
    parameter int DATA_W   = 32,
    parameter int PSUM_W   = 32,
    parameter int ACC_W    = 40,
    parameter bit SATURATE = 1'b1
) (
    input logic              clk,
    input logic              nRST,
    fusion_unit_pipe_if.slave bus
);

    typedef struct packed {
        logic [1:0] in_bw;
        logic [1:0] wt_bw;
        logic       in_signed;
        logic       wt_signed;
    } cfg_t;

    typedef struct packed {
        logic                     last;
        logic                     first;
        logic signed [ACC_W-1:0]  dot;
        logic signed [PSUM_W-1:0] psum_in;
    } s1_t;

    localparam int NMAX = DATA_W / 2;

    cfg_t                     cfg_live, cfg_hold, cfg_eff;
    logic                     grp_active;
    logic                     s1_vld;
    s1_t                      s1;
    logic                     accept, s2_adv;
    logic signed [ACC_W-1:0]  acc, dot_c, sum_c, result;
    logic                     fits;
    logic [PSUM_W-1:0]        psum_nxt;
    logic                     sat_nxt;
    logic                     out_vld_q, sat_q;
    logic [PSUM_W-1:0]        psum_q;
    logic [DATA_W-1:0]        fwd_q;
    logic                     fwd_vld_q;
    int                       bi, bw, n;
    logic signed [8:0]        a_e, b_e;
    logic signed [17:0]       prod;

    function automatic int width_of(input logic [1:0] code);
        case (code)
            2'd0:    return 2;
            2'd1:    return 4;
            default: return 8;
        endcase
    endfunction

    // Element k sits at bit bits*k; shifting the word keeps every select in range.
    function automatic logic signed [8:0] elem(input logic [DATA_W-1:0] word, input int bits,
                                               input int k, input logic sgn);
        logic [DATA_W-1:0] sh;
        sh = word >> (bits * k);
        case (bits)
            2:       return {{7{sgn & sh[1]}}, sh[1:0]};
            4:       return {{5{sgn & sh[3]}}, sh[3:0]};
            default: return {sgn & sh[7], sh[7:0]};
        endcase
    endfunction

    assign cfg_live = '{in_bw: bus.cfg_in_bw, wt_bw: bus.cfg_wt_bw,
                        in_signed: bus.cfg_in_signed, wt_signed: bus.cfg_wt_signed};
    assign cfg_eff  = grp_active ? cfg_hold : cfg_live;

    assign s2_adv       = s1_vld && (!s1.last || !out_vld_q || bus.out_ready);
    assign bus.in_ready = !s1_vld || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        bi    = width_of(cfg_eff.in_bw);
        bw    = width_of(cfg_eff.wt_bw);
        n     = DATA_W / ((bi > bw) ? bi : bw);
        dot_c = '0;
        a_e   = '0;
        b_e   = '0;
        prod  = '0;
        for (int k = 0; k < NMAX; k++) begin
            if (k < n) begin
                a_e   = elem(bus.input_forward, bi, k, cfg_eff.in_signed);
                b_e   = elem(bus.weight, bw, k, cfg_eff.wt_signed);
                prod  = a_e * b_e;
                dot_c = dot_c + ACC_W'(prod);
            end
        end
    end

    always_comb begin
        sum_c  = (s1.first ? '0 : acc) + s1.dot;
        result = sum_c + ACC_W'(s1.psum_in);
        fits   = (&result[ACC_W-1:PSUM_W-1]) || !(|result[ACC_W-1:PSUM_W-1]);
        psum_nxt = result[PSUM_W-1:0];
        sat_nxt  = 1'b0;
        if (SATURATE && !fits) begin
            psum_nxt = result[ACC_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
            sat_nxt  = 1'b1;
        end
    end

    // Config is latched on a group's first beat so mid-group changes are ignored.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            grp_active <= 1'b0;
            cfg_hold   <= '0;
        end else if (accept) begin
            if (!grp_active) cfg_hold <= cfg_live;
            grp_active <= !bus.in_last;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (accept) begin
            s1_vld <= 1'b1;
            s1     <= '{last: bus.in_last, first: !grp_active, dot: dot_c, psum_in: bus.psum_in};
        end else if (s2_adv) begin
            s1_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            acc       <= '0;
            out_vld_q <= 1'b0;
            psum_q    <= '0;
            sat_q     <= 1'b0;
        end else if (s2_adv && s1.last) begin
            acc       <= '0;
            out_vld_q <= 1'b1;
            psum_q    <= psum_nxt;
            sat_q     <= sat_nxt;
        end else begin
            if (s2_adv) acc <= sum_c;
            if (bus.out_ready) out_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            fwd_q     <= '0;
            fwd_vld_q <= 1'b0;
        end else begin
            fwd_vld_q <= accept;
            if (accept) fwd_q <= bus.input_forward;
        end
    end

    assign bus.out_valid      = out_vld_q;
    assign bus.psum           = psum_q;
    assign bus.sat            = sat_q;
    assign bus.input_to_right = fwd_q;
    assign bus.fwd_valid      = fwd_vld_q;

endmodule
